// File: rtl/mux2_rr_arbiter_if.sv
// Request/grant bundle between the two requesters and the mux2 select arbiter.
// The arbiter drives the slave side; the requester/bench side uses master.
interface mux2_rr_arbiter_if;
  logic       ReqA;
  logic       ReqB;
  logic       Sel;
  logic       GntA;
  logic       GntB;
  logic       Busy;
  logic [1:0] State;

  // Handshake: ReqX is level-sensitive and is held high for as long as the
  // requester wants the mux output. GntX high means the mux currently routes
  // requester X (Sel already matches). A requester releases ownership by
  // dropping ReqX; there is no separate ready/ack phase.
  modport master (
    output ReqA,
    output ReqB,
    input  Sel,
    input  GntA,
    input  GntB,
    input  Busy,
    input  State
  );

  modport slave (
    input  ReqA,
    input  ReqB,
    output Sel,
    output GntA,
    output GntB,
    output Busy,
    output State
  );
endinterface

// File: rtl/mux2_rr_arbiter.sv
// Round-robin owner of a mux2 Sel line: burst-capped grants with an optional
// turnaround gap so Sel settles before the new owner is granted.
module mux2_rr_arbiter #(
  parameter int unsigned MAX_BURST   = 4,
  parameter int unsigned TURN_CYCLES = 1
) (
  input  logic               CLK,
  input  logic               RST,
  mux2_rr_arbiter_if.slave   arb
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2,
    TURN  = 2'd3
  } state_e;

  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);
  localparam logic [1:0] TURN_LOAD = (TURN_CYCLES > 0) ? 2'(TURN_CYCLES - 1) : 2'd0;
  localparam bit         NO_TURN   = (TURN_CYCLES == 0);

  state_e     state_q, state_d;
  logic       sel_q, sel_d;
  logic       gnt_a_q, gnt_b_q;
  logic [3:0] burst_q, burst_d;
  logic       ptr_q, ptr_d;       // 0 = A has priority on a tie, 1 = B
  logic       target_q, target_d;
  logic [1:0] turn_q, turn_d;

  logic       arb_valid;
  logic       arb_side;
  logic       own_side;
  logic       own_req;
  logic       oth_req;
  logic       tgt_req;
  logic       take;
  logic       take_side;
  logic       hand;

  // Fresh arbitration from the raw requests, tie broken by the pointer.
  assign arb_valid = arb.ReqA | arb.ReqB;
  assign arb_side  = (arb.ReqA & arb.ReqB) ? ptr_q : arb.ReqB;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    burst_d   = burst_q;
    ptr_d     = ptr_q;
    target_d  = target_q;
    turn_d    = turn_q;
    take      = 1'b0;
    take_side = 1'b0;
    hand      = 1'b0;
    own_side  = (state_q == OWN_B);
    own_req   = own_side ? arb.ReqB : arb.ReqA;
    oth_req   = own_side ? arb.ReqA : arb.ReqB;
    tgt_req   = target_q ? arb.ReqB : arb.ReqA;

    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          take      = 1'b1;
          take_side = arb_side;
        end
      end

      OWN_A, OWN_B: begin
        if (!own_req && oth_req) begin
          hand = 1'b1;
        end else if (!own_req) begin
          state_d = IDLE;
          burst_d = 4'd0;
        end else if ((burst_q == BURST_MAX) && oth_req) begin
          hand = 1'b1;
        end else if (burst_q != BURST_MAX) begin
          burst_d = burst_q + 4'd1;
        end
      end

      TURN: begin
        if (turn_q != 2'd0) begin
          turn_d = turn_q - 2'd1;
        end else if (tgt_req) begin
          take      = 1'b1;
          take_side = target_q;
        end else if (arb_valid) begin
          take      = 1'b1;
          take_side = arb_side;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Ownership change: either through the turnaround gap or, with no gap,
    // straight into the other side's ownership on the same edge.
    if (hand) begin
      if (NO_TURN) begin
        take      = 1'b1;
        take_side = ~own_side;
      end else begin
        state_d  = TURN;
        target_d = ~own_side;
        sel_d    = ~own_side;
        turn_d   = TURN_LOAD;
        burst_d  = 4'd0;
      end
    end

    // Entering OWN_x: first owned cycle counts as burst 1, pointer flips away.
    if (take) begin
      state_d = take_side ? OWN_B : OWN_A;
      sel_d   = take_side;
      ptr_d   = ~take_side;
      burst_d = 4'd1;
      turn_d  = 2'd0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      sel_q    <= 1'b0;
      gnt_a_q  <= 1'b0;
      gnt_b_q  <= 1'b0;
      burst_q  <= 4'd0;
      ptr_q    <= 1'b0;
      target_q <= 1'b0;
      turn_q   <= 2'd0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      gnt_a_q  <= (state_d == OWN_A);
      gnt_b_q  <= (state_d == OWN_B);
      burst_q  <= burst_d;
      ptr_q    <= ptr_d;
      target_q <= target_d;
      turn_q   <= turn_d;
    end
  end

  assign arb.Sel   = sel_q;
  assign arb.GntA  = gnt_a_q;
  assign arb.GntB  = gnt_b_q;
  assign arb.Busy  = (state_q != IDLE);
  assign arb.State = state_q;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Bench for mux2_rr_arbiter: one instance with a 1-cycle turnaround and one
// with none, both MAX_BURST=4, checked against hand-derived grant patterns.
module tb_mux2_rr_arbiter;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  mux2_rr_arbiter_if bus0 ();
  mux2_rr_arbiter_if bus1 ();

  mux2_rr_arbiter #(.MAX_BURST(4), .TURN_CYCLES(1)) dut0 (
    .CLK (CLK),
    .RST (RST),
    .arb (bus0)
  );

  mux2_rr_arbiter #(.MAX_BURST(4), .TURN_CYCLES(0)) dut1 (
    .CLK (CLK),
    .RST (RST),
    .arb (bus1)
  );

  // Clock / reset
  always #5 CLK = ~CLK;

  int check_cnt = 0;
  int pass_cnt  = 0;
  logic [3:0] exp_q[$];

  // Observed vector order: {Sel, GntA, GntB, Busy}
  function automatic logic [3:0] obs0();
    return {bus0.Sel, bus0.GntA, bus0.GntB, bus0.Busy};
  endfunction

  function automatic logic [3:0] obs1();
    return {bus1.Sel, bus1.GntA, bus1.GntB, bus1.Busy};
  endfunction

  // Driver: apply requests to both instances, then sample #1 after the edge.
  task automatic tick(input logic a, input logic b);
    bus0.ReqA = a;
    bus0.ReqB = b;
    bus1.ReqA = a;
    bus1.ReqB = b;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    RST = 1'b0;
  endtask

  // Table entry: {rst, reqA, reqB, expected Sel, GntA, GntB, Busy}
  task automatic test_reset();
    logic [6:0] tbl [4] = '{7'b1_11_0000, 7'b1_11_0000, 7'b0_11_0101, 7'b0_00_0000};
    logic [3:0] exp;
    logic [3:0] got;
    for (int i = 0; i < 4; i++) begin
      RST = tbl[i][6];
      exp_q.push_back(tbl[i][3:0]);
      tick(tbl[i][5], tbl[i][4]);
      exp = exp_q.pop_front();
      got = obs0();
      check_cnt++;
      if (got !== exp) $display("FAIL reset[%0d] got %b want %b", i, got, exp);
      else pass_cnt++;
    end
    RST = 1'b0;
  endtask

  // Continues from test_reset: the first tie went to A, so B wins the next.
  task automatic test_tie();
    logic [5:0] tbl [4] = '{6'b11_1011, 6'b00_1000, 6'b11_0101, 6'b00_0000};
    logic [3:0] exp;
    logic [3:0] got;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(tbl[i][3:0]);
      tick(tbl[i][5], tbl[i][4]);
      exp = exp_q.pop_front();
      got = obs0();
      check_cnt++;
      if (got !== exp) $display("FAIL tie[%0d] got %b want %b", i, got, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_single();
    logic [3:0] exp;
    logic [3:0] got;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      exp_q.push_back((i < 10) ? 4'b1011 : 4'b1000);
      tick(1'b0, (i < 10));
      exp = exp_q.pop_front();
      got = obs0();
      check_cnt++;
      if (got !== exp) $display("FAIL single_b[%0d] got %b want %b", i, got, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_contention();
    logic [3:0] exp;
    logic [3:0] got;
    int n;
    int p;
    n = 10 * $urandom_range(2, 4);
    do_reset();
    for (int i = 0; i < n; i++) begin
      p = i % 10;
      if (p < 4)       exp_q.push_back(4'b0101);
      else if (p == 4) exp_q.push_back(4'b1001);
      else if (p < 9)  exp_q.push_back(4'b1011);
      else             exp_q.push_back(4'b0001);
      tick(1'b1, 1'b1);
      exp = exp_q.pop_front();
      got = obs0();
      check_cnt++;
      if (got !== exp) $display("FAIL contention[%0d] got %b want %b", i, got, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_turn0();
    logic [3:0] exp;
    logic [3:0] got;
    do_reset();
    for (int i = 0; i < 24; i++) begin
      exp_q.push_back(((i % 8) < 4) ? 4'b0101 : 4'b1011);
      tick(1'b1, 1'b1);
      exp = exp_q.pop_front();
      got = obs1();
      check_cnt++;
      if (got !== exp) $display("FAIL turn0[%0d] got %b want %b", i, got, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_drop_during_turn();
    logic [5:0] tbl [9] = '{6'b10_0101, 6'b11_0101, 6'b01_1001, 6'b10_0101, 6'b00_0000,
                            6'b10_0101, 6'b01_1001, 6'b00_1000, 6'b00_1000};
    logic [3:0] exp;
    logic [3:0] got;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(tbl[i][3:0]);
      tick(tbl[i][5], tbl[i][4]);
      exp = exp_q.pop_front();
      got = obs0();
      check_cnt++;
      if (got !== exp) $display("FAIL drop_turn[%0d] got %b want %b", i, got, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [6:0] tbl [11] = '{7'b0_01_1011, 7'b0_01_1011, 7'b1_01_0000, 7'b0_11_0101,
                             7'b0_00_0000, 7'b0_10_0101, 7'b1_10_0000, 7'b0_11_0101,
                             7'b0_01_1001, 7'b1_01_0000, 7'b0_00_0000};
    logic [3:0] exp;
    logic [3:0] got;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      RST = tbl[i][6];
      exp_q.push_back(tbl[i][3:0]);
      tick(tbl[i][5], tbl[i][4]);
      exp = exp_q.pop_front();
      got = obs0();
      check_cnt++;
      if (got !== exp) $display("FAIL reset_mid[%0d] got %b want %b", i, got, exp);
      else pass_cnt++;
    end
    RST = 1'b0;
  endtask

  initial begin
    bus0.ReqA = 1'b0;
    bus0.ReqB = 1'b0;
    bus1.ReqA = 1'b0;
    bus1.ReqB = 1'b0;
    test_reset();
    test_tie();
    test_single();
    test_contention();
    test_turn0();
    test_drop_during_turn();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
